// File: rtl/hpdcache_pkg.sv
// HPDcache shared types: configuration, CMO handler opcode,
// raw core-side CMO codes and their decoder.
package hpdcache_pkg;

    typedef struct packed {
        logic [7:0] nWays;
        logic [7:0] nSets;
    } hpdcache_cfg_t;

    typedef struct packed {
        logic is_inval_all;
        logic is_inval_by_set;
        logic is_inval_by_nline;
        logic is_fence;
    } hpdcache_cmoh_op_t;

    typedef enum logic [3:0] {
        HPDCACHE_CMO_FENCE          = 4'd0,
        HPDCACHE_CMO_INVAL_BY_NLINE = 4'd1,
        HPDCACHE_CMO_INVAL_BY_SET   = 4'd2,
        HPDCACHE_CMO_INVAL_ALL      = 4'd3
    } hpdcache_cmo_code_e;

    function automatic logic hpdcache_cmo_is_legal(logic [3:0] code);
        return (code < 4'd4);
    endfunction

    function automatic hpdcache_cmoh_op_t hpdcache_cmo_decode(
        logic       valid,
        logic [3:0] code
    );
        hpdcache_cmoh_op_t op;
        op = '0;
        if (valid) begin
            case (hpdcache_cmo_code_e'(code))
                HPDCACHE_CMO_FENCE:          op.is_fence          = 1'b1;
                HPDCACHE_CMO_INVAL_BY_NLINE: op.is_inval_by_nline = 1'b1;
                HPDCACHE_CMO_INVAL_BY_SET:   op.is_inval_by_set   = 1'b1;
                HPDCACHE_CMO_INVAL_ALL:      op.is_inval_all      = 1'b1;
                default:                     op                   = '0;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/hpdcache_cmo_dispatch.sv
// CMO dispatcher: serialises core CMO requests to the CMO handler
// and returns completion or illegal-opcode error responses.
module hpdcache_cmo_dispatch
    import hpdcache_pkg::*;
#(
    parameter hpdcache_cfg_t hpdcacheCfg = '0,
    parameter type hpdcache_req_addr_t = logic,
    parameter type hpdcache_req_data_t = logic,
    parameter type hpdcache_req_sid_t  = logic,
    parameter type hpdcache_req_tid_t  = logic
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               core_req_valid_i,
    output logic               core_req_ready_o,
    input  logic [3:0]         core_req_op_i,
    input  hpdcache_req_addr_t core_req_addr_i,
    input  hpdcache_req_data_t core_req_wdata_i,
    input  hpdcache_req_sid_t  core_req_sid_i,
    input  hpdcache_req_tid_t  core_req_tid_i,
    input  logic               core_req_need_rsp_i,

    output logic               core_rsp_valid_o,
    input  logic               core_rsp_ready_i,
    output hpdcache_req_sid_t  core_rsp_sid_o,
    output hpdcache_req_tid_t  core_rsp_tid_o,
    output logic               core_rsp_error_o,

    output logic               cmoh_req_valid_o,
    input  logic               cmoh_req_ready_i,
    output hpdcache_cmoh_op_t  cmoh_req_op_o,
    output hpdcache_req_addr_t cmoh_req_addr_o,
    output hpdcache_req_data_t cmoh_req_wdata_o,

    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RSP
    } state_e;

    state_e             state_q, state_d;
    hpdcache_cmoh_op_t  op_q;
    hpdcache_req_addr_t addr_q;
    hpdcache_req_data_t wdata_q;
    hpdcache_req_sid_t  sid_q;
    hpdcache_req_tid_t  tid_q;
    logic               need_rsp_q;
    logic               err_q;

    logic accept;
    logic legal;

    assign accept = (state_q == IDLE) && core_req_valid_i;
    assign legal  = hpdcache_cmo_is_legal(core_req_op_i);

    // Next-state logic of the dispatch FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (core_req_valid_i) begin
                    if (legal) begin
                        state_d = ISSUE;
                    end else if (core_req_need_rsp_i) begin
                        state_d = RSP;
                    end
                end
            end
            ISSUE: begin
                if (cmoh_req_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cmoh_req_ready_i) state_d = need_rsp_q ? RSP : IDLE;
            end
            RSP: begin
                if (core_rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Capture the request fields when a request is accepted in IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sid_q      <= '0;
            tid_q      <= '0;
            need_rsp_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            op_q       <= hpdcache_cmo_decode(legal, core_req_op_i);
            addr_q     <= core_req_addr_i;
            wdata_q    <= core_req_wdata_i;
            sid_q      <= core_req_sid_i;
            tid_q      <= core_req_tid_i;
            need_rsp_q <= core_req_need_rsp_i;
            err_q      <= ~legal;
        end
    end

    assign core_req_ready_o = (state_q == IDLE);
    assign cmoh_req_valid_o = (state_q == ISSUE);
    assign core_rsp_valid_o = (state_q == RSP);
    assign busy_o           = (state_q != IDLE);

    assign cmoh_req_op_o    = op_q;
    assign cmoh_req_addr_o  = addr_q;
    assign cmoh_req_wdata_o = wdata_q;
    assign core_rsp_sid_o   = sid_q;
    assign core_rsp_tid_o   = tid_q;
    assign core_rsp_error_o = err_q;

endmodule

// File: doc/hpdcache_cmo_dispatch.md
# hpdcache_cmo_dispatch

Upstream front-end of the HPDcache CMO handler. It accepts one cache-management request at a time from the core-side request port and decodes the raw operation code into the one-hot handler opcode. It then issues the request to the CMO handler, waits for the handler to finish, and, when the requester asked for one, returns a completion or error response. It serialises CMOs, so at most one is outstanding, and it rejects unsupported opcodes without disturbing the handler.

## Interface
Parameters:
- hpdcacheCfg, '0, HPDcache configuration struct
- hpdcache_req_addr_t, logic, request address type
- hpdcache_req_data_t, logic, request write-data type
- hpdcache_req_sid_t, logic, source-id type
- hpdcache_req_tid_t, logic, transaction-id type

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_valid_i  in  1  core CMO request valid
- core_req_ready_o  out  1  dispatcher can accept a request
- core_req_op_i  in  4  raw CMO code: 0 fence, 1 inval_by_nline, 2 inval_by_set, 3 inval_all, others illegal
- core_req_addr_i  in  addr  target address (nline ops)
- core_req_wdata_i  in  data  parameter word (way mask for inval_by_set)
- core_req_sid_i / core_req_tid_i  in  sid/tid  requester identifiers
- core_req_need_rsp_i  in  1  requester expects a response
- core_rsp_valid_o  out  1  response valid
- core_rsp_ready_i  in  1  response accepted
- core_rsp_sid_o / core_rsp_tid_o  out  sid/tid  echoed identifiers
- core_rsp_error_o  out  1  1 = illegal opcode
- cmoh_req_valid_o  out  1  request to CMO handler
- cmoh_req_ready_i  in  1  handler idle/ready
- cmoh_req_op_o  out  hpdcache_cmoh_op_t  one-hot handler opcode
- cmoh_req_addr_o  out  addr  registered address
- cmoh_req_wdata_o  out  data  registered parameter data
- busy_o  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, RSP.
- IDLE: core_req_ready_o=1. On valid, register op/addr/wdata/sid/tid/need_rsp and decode.
  - Legal op -> ISSUE.
  - Illegal op -> RSP with error=1 if need_rsp, else stay in IDLE and drop the request.
- ISSUE: cmoh_req_valid_o=1, with op/addr/wdata held stable until cmoh_req_ready_i. On handshake -> WAIT_DONE.
- WAIT_DONE: the first cycle with cmoh_req_ready_i=1 marks completion. The handler is busy in every cycle after acceptance except for a zero-wait fence, which stays ready.
  - On completion -> RSP if need_rsp, else IDLE.
- RSP: core_rsp_valid_o=1, with sid/tid/error held stable until core_rsp_ready_i -> IDLE.
- Decode: op 0..3 map to the one-hot fields is_fence, is_inval_by_nline, is_inval_by_set, is_inval_all. Exactly one bit is set; the output is all-zero when not valid.
- Error responses never assert cmoh_req_valid_o.

## Timing
- Reset values: fsm=IDLE; core_req_ready_o=1; core_rsp_valid_o=0; cmoh_req_valid_o=0; busy_o=0; data regs don't-care; core_rsp_error_o=0.
- Minimum legal latency, with the handler ready throughout:
  - accept at cycle 0;
  - cmoh_req_valid_o at cycle 1;
  - WAIT_DONE sees ready at cycle 2;
  - core_rsp_valid_o at cycle 3.
- Illegal-op latency: accept at cycle 0, core_rsp_valid_o at cycle 1.
- No combinational path from core_req_* to cmoh_req_* or core_rsp_*. All outputs come from registers or FSM state only.
- A new request is not accepted in the cycle an RSP handshake completes; it is accepted one cycle later, in IDLE.
- Backpressure on core_rsp_ready_i holds the FSM in RSP indefinitely.
- Asynchronous reset mid-operation returns to IDLE immediately. In-flight requests and responses are lost; the handler resets in the same domain.

## Structure
- Add the raw CMO opcode enum (hpdcache_cmo_code_e, 4 bits) and its decode function to hpdcache_pkg, next to hpdcache_cmoh_op_t.
- Single module, no sub-modules. The decoder is the package function; the FSM and registers are local.

## Test plan
- Fence, need_rsp=1, handler always ready -> cmoh op=4'b0001 at cycle 1, rsp valid at cycle 3 with echoed sid=2/tid=5, error=0.
- inval_by_set with wdata[0]=0x5 and handler ready low for 4 cycles after acceptance -> rsp appears 1 cycle after ready returns; cmoh_req_wdata_o=0x5 stable.
- inval_by_nline, need_rsp=0 -> handler issued, no core_rsp_valid_o, busy_o drops after completion.
- Opcode 7, need_rsp=1 -> error=1 rsp at cycle 1, cmoh_req_valid_o never set. Opcode 7 with need_rsp=0 -> dropped, ready stays 1.
- core_rsp_ready_i low for 10 cycles -> rsp fields stable, core_req_ready_o=0 throughout.
- rst_ni asserted during WAIT_DONE -> all valid outputs 0 and core_req_ready_o=1 immediately; a new request after release completes normally.
